// File: rtl/tx_arbiter.sv
// Frame-granular arbiter sharing one 64-bit MAC TX stream between N_PORTS encoders.
// Round-robin with optional port-0 priority; a beat watchdog truncates runaway frames.
module tx_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int MAX_BEATS = 32,
    parameter int PRIO0     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PORTS*64-1:0]  enc_tdata,
    input  logic [N_PORTS-1:0]     enc_tvalid,
    input  logic [N_PORTS-1:0]     enc_tlast,
    output logic [N_PORTS-1:0]     enc_tready,
    output logic [63:0]            mac_tdata,
    output logic                   mac_tvalid,
    output logic                   mac_tlast,
    input  logic                   mac_tready,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   err_oversize,
    output logic [31:0]            pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  grant_reg, grant_next;
    logic [2:0]  rr_ptr_reg, rr_ptr_next;
    logic [7:0]  beat_cnt_reg, beat_cnt_next;
    logic [31:0] pkt_cnt_reg, pkt_cnt_next;
    logic        err_oversize_reg, err_oversize_next;

    logic [N_PORTS-1:0] gnt_hot;
    logic [N_PORTS-1:0] hi_req;
    logic [63:0]        port_data [N_PORTS];
    logic [63:0]        sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               frame_end;
    logic               mac_hs;
    logic [2:0]         hi_pick;
    logic [2:0]         lo_pick;
    logic [2:0]         winner;

    // hi_req marks valid ports at or above rr_ptr, so the round-robin scan is
    // "lowest hi_req, else lowest valid overall" without any modulo arithmetic.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign port_data[gi] = enc_tdata[gi*64 +: 64];
            assign gnt_hot[gi]   = (grant_reg == 3'(gi));
            assign hi_req[gi]    = enc_tvalid[gi] && (3'(gi) >= rr_ptr_reg);
        end
    endgenerate

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_hot[i]) begin
                sel_data  = port_data[i];
                sel_valid = enc_tvalid[i];
                sel_last  = enc_tlast[i];
            end
        end
    end

    always_comb begin
        hi_pick = '0;
        lo_pick = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (enc_tvalid[i]) lo_pick = 3'(i);
            if (hi_req[i])     hi_pick = 3'(i);
        end
        if ((PRIO0 != 0) && enc_tvalid[0]) winner = '0;
        else if (|hi_req)                  winner = hi_pick;
        else                               winner = lo_pick;
    end

    assign frame_end = sel_last || (beat_cnt_reg == 8'(MAX_BEATS - 1));
    assign mac_hs    = (state_reg == BURST) && sel_valid && mac_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            grant_reg        <= '0;
            rr_ptr_reg       <= '0;
            beat_cnt_reg     <= '0;
            pkt_cnt_reg      <= '0;
            err_oversize_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            rr_ptr_reg       <= rr_ptr_next;
            beat_cnt_reg     <= beat_cnt_next;
            pkt_cnt_reg      <= pkt_cnt_next;
            err_oversize_reg <= err_oversize_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        rr_ptr_next       = rr_ptr_reg;
        beat_cnt_next     = beat_cnt_reg;
        pkt_cnt_next      = pkt_cnt_reg;
        err_oversize_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|enc_tvalid) begin
                    grant_next    = winner;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (mac_hs) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (frame_end) begin
                        pkt_cnt_next = pkt_cnt_reg + 32'd1;
                        rr_ptr_next  = (grant_reg == 3'(N_PORTS - 1)) ? 3'd0 : grant_reg + 3'd1;
                        if (sel_last) begin
                            state_next = IDLE;
                        end else begin
                            err_oversize_next = 1'b1;
                            state_next        = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (sel_valid && sel_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mac_tvalid = 1'b0;
        mac_tlast  = 1'b0;
        enc_tready = '0;
        case (state_reg)
            BURST: begin
                mac_tvalid = sel_valid;
                mac_tlast  = frame_end;
                enc_tready = gnt_hot & {N_PORTS{mac_tready}};
            end
            DROP: begin
                enc_tready = gnt_hot;
            end
            default: ;
        endcase
    end

    assign mac_tdata    = sel_data;
    assign grant_id     = grant_reg;
    assign busy         = (state_reg != IDLE);
    assign err_oversize = err_oversize_reg;
    assign pkt_cnt      = pkt_cnt_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomised and directed bench for tx_arbiter; a frame-level behavioural model
// predicts every output on every cycle, and directed sequences pin literal results.
module tb_tx_arbiter;

    localparam int NP = 4;
    localparam int MB = 4;
    localparam int PR = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*64-1:0]  enc_tdata;
    logic [NP-1:0]     enc_tvalid;
    logic [NP-1:0]     enc_tlast;
    logic [NP-1:0]     enc_tready;
    logic [63:0]       mac_tdata;
    logic              mac_tvalid;
    logic              mac_tlast;
    logic              mac_tready;
    logic [2:0]        grant_id;
    logic              busy;
    logic              err_oversize;
    logic [31:0]       pkt_cnt;

    always #5 clk = ~clk;

    tx_arbiter #(.N_PORTS(NP), .MAX_BEATS(MB), .PRIO0(PR)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_tdata(enc_tdata), .enc_tvalid(enc_tvalid), .enc_tlast(enc_tlast),
        .enc_tready(enc_tready),
        .mac_tdata(mac_tdata), .mac_tvalid(mac_tvalid), .mac_tlast(mac_tlast),
        .mac_tready(mac_tready),
        .grant_id(grant_id), .busy(busy), .err_oversize(err_oversize), .pkt_cnt(pkt_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Encoder sources: per-port queue of pending frames (length, first data word).
    int          flen_q [NP][$];
    logic [63:0] fbase_q[NP][$];
    int          bidx   [NP];
    int          vprob = 100;
    int          rprob = 100;
    int          rmode = 0;
    int          rpat  = 0;

    // Frame-level model of the arbiter.
    typedef enum {M_IDLE, M_BURST, M_DROP} mstate_t;
    mstate_t     m_st = M_IDLE;
    int          m_g = 0, m_rr = 0, m_beats = 0;
    logic [31:0] m_pkt = '0;
    bit          m_err = 1'b0;
    bit          armed = 1'b0;

    logic [63:0] log_d[$];
    bit          log_l[$];
    int          done_q[$];
    int          err_seen = 0;
    int          cyc = 0;
    int          first_req = -1;
    int          first_vld = -1;
    int          mbeats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_winner(input logic [NP-1:0] v);
        if (PR != 0 && v[0]) return 0;
        for (int k = 0; k < NP; k++) begin
            if (v[(m_rr + k) % NP]) return (m_rr + k) % NP;
        end
        return 0;
    endfunction

    // Drive encoder and MAC inputs just after each rising edge.
    initial begin
        enc_tvalid = '0;
        enc_tlast  = '0;
        enc_tdata  = '0;
        mac_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (flen_q[p].size() > 0 && int'($urandom_range(99)) < vprob) begin
                    enc_tvalid[p]        = 1'b1;
                    enc_tdata[p*64 +: 64] = fbase_q[p][0] + 64'(bidx[p]);
                    enc_tlast[p]         = (bidx[p] == flen_q[p][0] - 1);
                end else begin
                    enc_tvalid[p]        = 1'b0;
                    enc_tlast[p]         = 1'b0;
                    enc_tdata[p*64 +: 64] = {$urandom, $urandom};
                end
            end
            if (rmode == 1) mac_tready = (rpat % 3 == 0);
            else            mac_tready = (int'($urandom_range(99)) < rprob);
            rpat++;
        end
    end

    // Compare DUT against model on the falling edge, then advance the model.
    initial begin
        logic [NP-1:0] exp_rdy;
        bit exp_v, exp_l, nerr;
        forever begin
            @(negedge clk);
            cyc++;
            exp_rdy = '0;
            exp_v   = 1'b0;
            exp_l   = 1'b0;
            if (m_st == M_BURST) begin
                exp_v          = enc_tvalid[m_g];
                exp_l          = enc_tlast[m_g] || (m_beats == MB - 1);
                exp_rdy[m_g]   = mac_tready;
            end else if (m_st == M_DROP) begin
                exp_rdy[m_g]   = 1'b1;
            end
            if (armed) begin
                chk("mac_tvalid", 64'(mac_tvalid), 64'(exp_v));
                chk("mac_tlast", 64'(mac_tlast), 64'(exp_l));
                chk("enc_tready", 64'(enc_tready), 64'(exp_rdy));
                chk("busy", 64'(busy), 64'(m_st != M_IDLE));
                chk("grant_id", 64'(grant_id), 64'(m_g));
                chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
                chk("err_oversize", 64'(err_oversize), 64'(m_err));
                if (m_st == M_BURST) chk("mac_tdata", mac_tdata, enc_tdata[m_g*64 +: 64]);
            end
            if (first_req < 0 && |enc_tvalid) first_req = cyc;
            if (first_vld < 0 && mac_tvalid)  first_vld = cyc;
            if (err_oversize) err_seen++;
            if (mac_tvalid && mac_tready && rst_n) begin
                log_d.push_back(mac_tdata);
                log_l.push_back(mac_tlast);
                mbeats++;
                if (mac_tlast) begin
                    done_q.push_back(int'(grant_id));
                    $display("[TB] frame port %0d beats %0d pkt_cnt %0d", grant_id, mbeats, pkt_cnt + 1);
                    mbeats = 0;
                end
            end
            if (!rst_n) begin
                m_st = M_IDLE; m_g = 0; m_rr = 0; m_beats = 0; m_pkt = '0; m_err = 1'b0;
                mbeats = 0;
                armed = 1'b1;
            end else begin
                nerr = 1'b0;
                case (m_st)
                    M_IDLE: if (|enc_tvalid) begin
                        m_g = pick_winner(enc_tvalid);
                        m_beats = 0;
                        m_st = M_BURST;
                    end
                    M_BURST: if (exp_v && mac_tready) begin
                        m_beats++;
                        if (exp_l) begin
                            m_pkt++;
                            m_rr = (m_g + 1) % NP;
                            if (enc_tlast[m_g]) m_st = M_IDLE;
                            else begin nerr = 1'b1; m_st = M_DROP; end
                        end
                    end
                    M_DROP: if (enc_tvalid[m_g] && enc_tlast[m_g]) m_st = M_IDLE;
                    default: m_st = M_IDLE;
                endcase
                m_err = nerr;
                for (int p = 0; p < NP; p++) begin
                    if (enc_tvalid[p] && exp_rdy[p]) begin
                        bidx[p]++;
                        if (bidx[p] == flen_q[p][0]) begin
                            void'(flen_q[p].pop_front());
                            void'(fbase_q[p].pop_front());
                            bidx[p] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            flen_q[p].delete();
            fbase_q[p].delete();
            bidx[p] = 0;
        end
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        done_q.delete();
        err_seen  = 0;
        first_req = -1;
        first_vld = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        tick(1);
    endtask

    task automatic push(input int p, input int len, input logic [63:0] base);
        flen_q[p].push_back(len);
        fbase_q[p].push_back(base);
    endtask

    function automatic bit src_empty();
        for (int p = 0; p < NP; p++) if (flen_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int maxc);
        int k = 0;
        while ((!src_empty() || m_st != M_IDLE) && k < maxc) begin
            tick(1);
            k++;
        end
        tests++;
        if (k >= maxc) begin
            fails++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic chk_log(input string name, input int n, input logic [63:0] base, input int last_at);
        chk({name, "_beats"}, 64'(log_d.size()), 64'(n));
        if (log_d.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({name, "_data"}, log_d[i], base + 64'(i));
                chk({name, "_last"}, 64'(log_l[i]), 64'(i == last_at));
            end
        end
    endtask

    initial begin
        int k;
        int exp_order[9];
        rst_n = 1'b0;
        clear_src();
        tick(1);

        // Reset state
        do_reset();
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mac_tvalid", 64'(mac_tvalid), 64'd0);
        chk("rst_enc_tready", 64'(enc_tready), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);

        // Single port 2, 3-beat frame
        push(2, 3, 64'hA0);
        wait_drain("t1", 30);
        chk("t1_latency", 64'(first_vld - first_req), 64'd1);
        chk_log("t1", 3, 64'hA0, 2);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_grant_id", 64'(grant_id), 64'd2);
        chk("t1_model_rr", 64'(m_rr), 64'd3);

        // All ports request 2-beat frames at once
        do_reset();
        for (int p = 0; p < NP; p++) push(p, 2, 64'(32'h100 * p));
        tick(12);
        chk("t2_pkt_cnt_11", 64'(pkt_cnt), 64'd3);
        tick(1);
        chk("t2_pkt_cnt_12", 64'(pkt_cnt), 64'd4);
        chk("t2_frames", 64'(done_q.size()), 64'd4);
        if (done_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_order", 64'(done_q[i]), 64'(i));

        // Port 0 priority over a continuously requesting port 1
        do_reset();
        for (int f = 0; f < 6; f++) push(0, 2, 64'(32'h200 + 16 * f));
        for (int f = 0; f < 3; f++) push(1, 2, 64'(32'h300 + 16 * f));
        wait_drain("t3", 100);
        for (int i = 0; i < 9; i++) exp_order[i] = (i < 6) ? 0 : 1;
        chk("t3_frames", 64'(done_q.size()), 64'd9);
        if (done_q.size() == 9)
            for (int i = 0; i < 9; i++) chk("t3_order", 64'(done_q[i]), 64'(exp_order[i]));

        // Oversize truncation, exact-limit frame, one-beat frame
        do_reset();
        push(1, 6, 64'h10);
        wait_drain("t4a", 40);
        chk_log("t4a", 4, 64'h10, 3);
        chk("t4a_err_pulses", 64'(err_seen), 64'd1);
        chk("t4a_pkt_cnt", 64'(pkt_cnt), 64'd1);
        clear_logs();
        push(3, 4, 64'h30);
        wait_drain("t4b", 40);
        chk_log("t4b", 4, 64'h30, 3);
        chk("t4b_err_pulses", 64'(err_seen), 64'd0);
        chk("t4b_pkt_cnt", 64'(pkt_cnt), 64'd2);
        clear_logs();
        push(2, 1, 64'h50);
        wait_drain("t4c", 20);
        chk_log("t4c", 1, 64'h50, 0);
        chk("t4c_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Backpressure, then reset mid-frame
        do_reset();
        rmode = 1;
        rpat  = 0;
        push(0, 5, 64'h70);
        k = 0;
        while (log_d.size() < 3 && k < 60) begin
            tick(1);
            k++;
        end
        chk("t5_three_beats", 64'(log_d.size()), 64'd3);
        chk_log("t5", 3, 64'h70, -1);
        rst_n = 1'b0;
        clear_src();
        tick(1);
        chk("t5_rst_mac_tvalid", 64'(mac_tvalid), 64'd0);
        chk("t5_rst_enc_tready", 64'(enc_tready), 64'd0);
        chk("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        rmode = 0;
        tick(1);

        // Random traffic
        do_reset();
        vprob = 75;
        rprob = 70;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(3) == 0) begin
                int p;
                p = int'($urandom_range(NP - 1));
                if (flen_q[p].size() < 3) push(p, int'($urandom_range(1, 7)), {$urandom, $urandom});
            end
            tick(1);
        end
        vprob = 100;
        rprob = 100;
        wait_drain("rand", 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Packet-granular arbiter that shares the single 64-bit network MAC transmit stream between `N_PORTS` encoder output streams. It sits between the encoders and the TX bridge/MAC. A grant is held for a whole frame, from first beat to `tlast`, so frames are never interleaved. Selection is round-robin, with optional strict priority for port 0 (cancel/kill-switch encoder). A beat-count watchdog truncates runaway frames and discards their remainder.

## Interface
Parameters:
- `N_PORTS`, 4: number of encoder inputs, 2..8.
- `MAX_BEATS`, 32: maximum beats per frame, 2..255.
- `PRIO0`, 1: 1 = port 0 wins any arbitration in which it is valid; 0 = pure round-robin.

Ports:
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: synchronous, active-low reset.
- `enc_tdata` input `N_PORTS*64`: port i occupies bits [64i+63:64i].
- `enc_tvalid` input `N_PORTS`: per-port valid.
- `enc_tlast` input `N_PORTS`: per-port end of frame.
- `enc_tready` output `N_PORTS`: per-port ready.
- `mac_tdata` output 64: selected data.
- `mac_tvalid` output 1: selected valid.
- `mac_tlast` output 1: end of frame, including forced end of frame.
- `mac_tready` input 1: MAC ready.
- `grant_id` output 3: index of the port currently or last granted.
- `busy` output 1: high in BURST or DROP.
- `err_oversize` output 1: one-cycle pulse when a frame is truncated.
- `pkt_cnt` output 32: count of frames completed on the MAC side, wraps at 2^32.

## Operation
States: IDLE, BURST, DROP. Registers: `state`, `grant`, `rr_ptr`, `beat_cnt` (8 bit), `pkt_cnt`, `err_oversize`.

IDLE:
- All `enc_tready` = 0; `mac_tvalid` = 0.
- If no `enc_tvalid` bit is set, stay in IDLE.
- Otherwise select a winner:
  - PRIO0=1 and `enc_tvalid[0]` set: winner = 0.
  - Else winner = first valid port scanning `rr_ptr`, `rr_ptr`+1, … modulo `N_PORTS`.
- Register winner into `grant`, clear `beat_cnt`, go to BURST.

BURST:
- Datapath is combinational from the granted port:
  - `mac_tdata` = `enc_tdata[grant]`
  - `mac_tvalid` = `enc_tvalid[grant]`
  - `enc_tready[grant]` = `mac_tready`; all other readies = 0.
- `mac_tlast` = `enc_tlast[grant]` OR (`beat_cnt` == `MAX_BEATS`-1).
- On each handshake (`mac_tvalid` & `mac_tready`), `beat_cnt` increments.
- Handshake with `mac_tlast` = 1:
  - `pkt_cnt` increments.
  - `rr_ptr` = (`grant`+1) mod `N_PORTS`. This happens even when grant came from priority.
  - If `enc_tlast[grant]` = 1: go to IDLE.
  - Else (forced truncation): pulse `err_oversize` for one cycle, go to DROP.

DROP:
- `mac_tvalid` = 0; `enc_tready[grant]` = 1 (discard beats); other readies = 0.
- On an input handshake with `enc_tlast[grant]` = 1, go to IDLE. Discarded beats are not counted.

Boundary rules:
- A frame whose natural `tlast` falls exactly on beat `MAX_BEATS` is normal: no error, no DROP.
- A one-beat frame is legal.
- A granted port dropping `tvalid` mid-frame stalls the MAC stream. There is no timeout and the grant is held.
- Simultaneous requests from all ports under round-robin are served in `rr_ptr` order, one frame each.
- `grant_id` = `grant` at all times. It holds its value in IDLE.

## Timing
- Reset values, applied at the first edge with `rst_n` = 0:
  - `state` = IDLE, `grant` = 0, `rr_ptr` = 0, `beat_cnt` = 0, `pkt_cnt` = 0, `err_oversize` = 0.
  - Hence `mac_tvalid` = 0, `mac_tlast` = 0, `enc_tready` = 0, `busy` = 0.
- Reset asserted mid-frame aborts immediately. The MAC sees a frame without `tlast`; MAC-side cleanup is out of scope for this block.
- Arbitration latency: a request seen in an IDLE cycle n gives `mac_tvalid` at the earliest in cycle n+1.
- There is exactly one IDLE bubble cycle between consecutive frames. Within a frame, throughput is one beat per cycle.
- `mac_tready` to `enc_tready` is a combinational path with no register stage.
- `err_oversize` is high in the cycle after the truncating handshake, for exactly one cycle.

## Test plan
- Single port: port 2 sends a 3-beat frame with data 0xA0..0xA2 and `mac_tready` = 1.
  - `mac_tvalid` is first seen 1 cycle after the request; 3 beats are delivered with `tlast` on 0xA2.
  - Then `pkt_cnt` = 1, `rr_ptr` = 3, `grant_id` = 2.
- Round-robin (PRIO0=0): all 4 ports hold 2-beat frames from reset.
  - Grant order is 0,1,2,3 with one bubble between frames; `pkt_cnt` = 4 after 12 cycles.
- Priority (PRIO0=1): ports 0 and 1 request continuously, `rr_ptr` = 1.
  - Port 0 wins every arbitration; port 1 is never granted while `enc_tvalid[0]` stays high.
- Oversize: MAX_BEATS=4, port 1 sends 6 beats.
  - MAC receives 4 beats with forced `tlast` on beat 4; `err_oversize` pulses once.
  - Beats 5–6 are accepted and discarded; `pkt_cnt` += 1; the block then returns to IDLE.
- Backpressure and reset: 5-beat frame with `mac_tready` toggling 1,0,0,1,…
  - Data is held stable and no beats are lost or duplicated.
  - `rst_n` = 0 after beat 3 gives `mac_tvalid` = 0 and all readies = 0 on the next edge, with `pkt_cnt` = 0.
